fetch_unit: RTL

//   Instruction-fetch stage of the single-cycle stack CPU, directly upstream of inst_mem.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fetch_pc_reg.sv | 36 +++
 rtl/fetch_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// Package : cpu_pkg
// Shared widths, opcodes and small helper types for the stack CPU front end.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  // Default datapath widths
  localparam int CPU_ABITS    = 32;
  localparam int CPU_DBITS    = 32;
  localparam int CPU_OPC_BITS = 8;

  // Opcodes that matter to the front end (decode owns the rest)
  localparam logic [CPU_OPC_BITS-1:0] OP_BR   = 8'h20;
  localparam logic [CPU_OPC_BITS-1:0] OP_JMP  = 8'h21;
  localparam logic [CPU_OPC_BITS-1:0] OP_CALL = 8'h22;
  localparam logic [CPU_OPC_BITS-1:0] OP_RET  = 8'h23;
  localparam logic [CPU_OPC_BITS-1:0] OP_HALT = 8'hFF;

  // Program-counter update selection
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_op_e;

  // True for opcodes that end in a redirect from decode/execute
  function automatic logic is_ctrl_flow(input logic [CPU_OPC_BITS-1:0] opc);
    return (opc == OP_BR) || (opc == OP_JMP) || (opc == OP_CALL) || (opc == OP_RET);
  endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ---------------------------------------------------------------------------
// Module  : fetch_pc_reg
// Program counter with load / increment / hold, wrapping modulo 2^ABITS.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int               ABITS    = CPU_ABITS,
  parameter logic [ABITS-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  pc_op_e           op,
  input  logic [ABITS-1:0] load_pc,
  output logic [ABITS-1:0] pc
);

  // PC register: reset dominates, then load, increment or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (op)
        PC_LOAD: pc <= load_pc;
        PC_INC:  pc <= pc + ABITS'(1);
        default: pc <= pc;
      endcase
    end
  end

endmodule : fetch_pc_reg

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// Module  : fetch_unit
// Instruction fetch: owns the PC, registers inst_mem output into the IR and
// hands it to decode over valid/ready. Handles redirects and HALT.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  ABITS       = CPU_ABITS,
  parameter int                  DBITS       = CPU_DBITS,
  parameter logic [ABITS-1:0]    RESET_PC    = '0,
  parameter int                  OPC_BITS    = CPU_OPC_BITS,
  parameter logic [OPC_BITS-1:0] HALT_OPCODE = OP_HALT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_en,
  output logic [ABITS-1:0] imem_addr,
  input  logic [DBITS-1:0] imem_dout,
  output logic [DBITS-1:0] inst_out,
  output logic [ABITS-1:0] inst_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             redirect_valid,
  input  logic [ABITS-1:0] redirect_pc,
  output logic             halted
);

  logic [ABITS-1:0]    pc;
  logic                adv;
  logic                redirect_take;
  logic                fetch_is_halt;
  logic [OPC_BITS-1:0] fetch_opc;
  pc_op_e              pc_op;

  // Advance/redirect decisions and PC update selection.
  // A halted unit ignores redirects; redirect outranks a normal advance.
  always_comb begin
    adv           = ~halted & (~inst_valid | inst_ready);
    redirect_take = redirect_valid & ~halted;
    fetch_opc     = imem_dout[DBITS-1 -: OPC_BITS];
    fetch_is_halt = (fetch_opc == HALT_OPCODE);
    pc_op         = PC_HOLD;
    if (redirect_take) begin
      pc_op = PC_LOAD;
    end else if (adv) begin
      pc_op = PC_INC;
    end
  end

  fetch_pc_reg #(
    .ABITS    (ABITS),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .op      (pc_op),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  assign imem_en   = ~halted;
  assign imem_addr = pc;

  // IR, its address, valid flag and halt flag.
  // Once halted, the only change is dropping valid after the HALT word
  // has been taken by decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (redirect_take) begin
      inst_valid <= 1'b0;
    end else if (adv) begin
      inst_out   <= imem_dout;
      inst_pc    <= pc;
      inst_valid <= 1'b1;
      if (fetch_is_halt) begin
        halted <= 1'b1;
      end
    end else if (halted && inst_valid && inst_ready) begin
      inst_valid <= 1'b0;
    end
  end

endmodule : fetch_unit

`default_nettype wire
